da_tap_serializer: RTL and testbench

Input-side feeder for the distributed-arithmetic FIR core (`distr_arith`). It accepts one input sample at a time over a valid/ready handshake and shifts it into an 8-tap sample delay line. It drives the eight parallel tap words `x1_bit`..`x8_bit`. It then walks bit-serially through those taps for `DATA_W` cycles and emits the per-bit LUT address slice with framing strobes.

---
 rtl/da_tap_serializer.sv | 127 ++++++++++++
 tb/tb_da_tap_serializer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/da_tap_serializer.sv
// da_tap_serializer: input feeder for the distributed-arithmetic FIR core.
// Accepts one sample per valid/ready handshake into an 8-tap delay line.
// It then walks the taps bit-serially for DATA_W cycles. Each cycle it
// presents one LUT address slice (one bit from every tap) plus framing strobes.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   in_valid, in_data     sample offer (two's complement, DATA_W bits)
//   in_ready              accept indication (high in IDLE, low during reset)
//   x1_bit..x8_bit        tap words, x1 newest, x8 oldest
//   slice                 slice[k-1] = xk_bit[bit_idx]
//   slice_valid           slice is valid this cycle
//   bit_idx               current bit position, 0 = LSB
//   slice_msb             current slice holds the sign bits
//   frame_start           pulse with the first slice of a frame
//   frame_done            pulse with the last slice of a frame
module da_tap_serializer #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned TAPS   = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic [DATA_W-1:0] x1_bit,
   output logic [DATA_W-1:0] x2_bit,
   output logic [DATA_W-1:0] x3_bit,
   output logic [DATA_W-1:0] x4_bit,
   output logic [DATA_W-1:0] x5_bit,
   output logic [DATA_W-1:0] x6_bit,
   output logic [DATA_W-1:0] x7_bit,
   output logic [DATA_W-1:0] x8_bit,
   output logic [TAPS-1:0]   slice,
   output logic              slice_valid,
   output logic [2:0]        bit_idx,
   output logic              slice_msb,
   output logic              frame_start,
   output logic              frame_done
);

   localparam int unsigned IDX_W = 3;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

   typedef enum logic {
      IDLE   = 1'b0,
      SERIAL = 1'b1
   } state_t;

   state_t            state;
   logic [DATA_W-1:0] taps [TAPS];
   logic [IDX_W-1:0]  idx;
   logic [IDX_W-1:0]  idx_next;

   assign idx_next = idx + IDX_W'(1);

   // Control FSM, delay line and registered framing strobes
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         idx         <= '0;
         slice_valid <= 1'b0;
         slice_msb   <= 1'b0;
         frame_start <= 1'b0;
         frame_done  <= 1'b0;
         for (int i = 0; i < int'(TAPS); i++) begin
            taps[i] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  for (int i = int'(TAPS) - 1; i > 0; i--) begin
                     taps[i] <= taps[i-1];
                  end
                  taps[0]     <= in_data;
                  idx         <= '0;
                  state       <= SERIAL;
                  slice_valid <= 1'b1;
                  frame_start <= 1'b1;
                  slice_msb   <= (LAST_IDX == '0);
                  frame_done  <= (LAST_IDX == '0);
               end
            end
            SERIAL: begin
               frame_start <= 1'b0;
               if (idx == LAST_IDX) begin
                  state       <= IDLE;
                  idx         <= '0;
                  slice_valid <= 1'b0;
                  slice_msb   <= 1'b0;
                  frame_done  <= 1'b0;
               end else begin
                  idx        <= idx_next;
                  slice_msb  <= (idx_next == LAST_IDX);
                  frame_done <= (idx_next == LAST_IDX);
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Ready comes from registered state only; held low while reset is applied
   assign in_ready = (state == IDLE) && !reset;
   assign bit_idx  = idx;

   // One address bit per tap, selected by the current bit position
   always_comb begin
      slice = '0;
      for (int k = 0; k < int'(TAPS); k++) begin
         slice[k] = taps[k][idx];
      end
   end

   assign x1_bit = taps[0];
   assign x2_bit = taps[1];
   assign x3_bit = taps[2];
   assign x4_bit = taps[3];
   assign x5_bit = taps[4];
   assign x6_bit = taps[5];
   assign x7_bit = taps[6];
   assign x8_bit = taps[7];

endmodule

// File: tb/tb_da_tap_serializer.sv
// tb_da_tap_serializer: randomized and directed stimulus for da_tap_serializer.
// A negedge monitor keeps a sample-level model of the delay line. Each accept
// pushes the eight expected slices of the frame into a scoreboard queue. The
// monitor pops one entry for every cycle in which the DUT presents a slice.
module tb_da_tap_serializer;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned TAPS   = 8;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              in_valid = 1'b0;
   logic [DATA_W-1:0] in_data = '0;
   logic              in_ready;
   logic [DATA_W-1:0] x1_bit, x2_bit, x3_bit, x4_bit, x5_bit, x6_bit, x7_bit, x8_bit;
   logic [TAPS-1:0]   slice;
   logic              slice_valid;
   logic [2:0]        bit_idx;
   logic              slice_msb, frame_start, frame_done;

   da_tap_serializer #(.DATA_W(DATA_W), .TAPS(TAPS)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready),
      .x1_bit(x1_bit), .x2_bit(x2_bit), .x3_bit(x3_bit), .x4_bit(x4_bit),
      .x5_bit(x5_bit), .x6_bit(x6_bit), .x7_bit(x7_bit), .x8_bit(x8_bit),
      .slice(slice), .slice_valid(slice_valid), .bit_idx(bit_idx),
      .slice_msb(slice_msb), .frame_start(frame_start), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   logic [DATA_W-1:0] xs [TAPS];
   assign xs[0] = x1_bit;
   assign xs[1] = x2_bit;
   assign xs[2] = x3_bit;
   assign xs[3] = x4_bit;
   assign xs[4] = x5_bit;
   assign xs[5] = x6_bit;
   assign xs[6] = x7_bit;
   assign xs[7] = x8_bit;

   typedef struct {
      logic [TAPS-1:0] slice;
      int              idx;
      logic            msb;
      logic            start;
      logic            done;
   } exp_t;

   exp_t              sbq [$];
   logic [DATA_W-1:0] mline [TAPS];
   int                mcnt = 0;       // serial cycles still owed by the model
   bit                mvalid = 1'b0;  // model is meaningful once reset was seen
   bit                cont = 1'b0;    // continuous-valid phase: check accept spacing
   int                last_acc = -1;
   int                cyc = 0;
   int                total = 0;
   int                bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: compare the current cycle, then advance the model over the next edge
   always @(negedge clk) begin
      exp_t e;
      cyc++;
      if (cyc > 20000) begin
         $display("FAIL timeout actual=%0d expected<=20000", cyc);
         $fatal(1, "cycle budget exhausted");
      end
      if (mvalid) begin
         chk("in_ready", 32'(in_ready), 32'(mcnt == 0 && !reset));
         chk("slice_valid", 32'(slice_valid), 32'(mcnt != 0));
         for (int k = 0; k < int'(TAPS); k++) begin
            chk($sformatf("tap%0d", k + 1), 32'(xs[k]), 32'(mline[k]));
         end
         if (slice_valid) begin
            if (sbq.size() == 0) begin
               chk("unexpected_slice", 32'(1), 32'(0));
            end else begin
               e = sbq.pop_front();
               chk("slice", 32'(slice), 32'(e.slice));
               chk("bit_idx", 32'(bit_idx), 32'(e.idx));
               chk("slice_msb", 32'(slice_msb), 32'(e.msb));
               chk("frame_start", 32'(frame_start), 32'(e.start));
               chk("frame_done", 32'(frame_done), 32'(e.done));
            end
         end else begin
            chk("idle_strobes", 32'({slice_msb, frame_start, frame_done}), 32'(0));
         end
      end

      if (reset) begin
         mvalid = 1'b1;
         mcnt   = 0;
         sbq.delete();
         for (int k = 0; k < int'(TAPS); k++) mline[k] = '0;
      end else if (mvalid) begin
         if (mcnt == 0 && in_valid) begin
            for (int k = int'(TAPS) - 1; k > 0; k--) mline[k] = mline[k-1];
            mline[0] = in_data;
            for (int b = 0; b < int'(DATA_W); b++) begin
               for (int k = 0; k < int'(TAPS); k++) e.slice[k] = mline[k][b];
               e.idx   = b;
               e.msb   = (b == int'(DATA_W) - 1);
               e.start = (b == 0);
               e.done  = (b == int'(DATA_W) - 1);
               sbq.push_back(e);
            end
            if (cont && last_acc >= 0) chk("accept_gap", 32'(cyc - last_acc), 32'(DATA_W + 1));
            last_acc = cyc;
            mcnt = int'(DATA_W);
         end else if (mcnt != 0) begin
            mcnt--;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      reset    = 1'b1;
      in_valid = 1'b0;
      repeat (n) tick();
      reset = 1'b0;
   endtask

   task automatic post_reset_check();
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'(1));
      chk("rst_slice", 32'(slice), 32'(0));
      chk("rst_bit_idx", 32'(bit_idx), 32'(0));
      chk("rst_x1", 32'(x1_bit), 32'(0));
      chk("rst_x8", 32'(x8_bit), 32'(0));
   endtask

   // Offer d until accepted; scramble changes the data every refused cycle
   task automatic send(input logic [DATA_W-1:0] d, input bit scramble, input bit keep_valid);
      bit ok;
      int n;
      ok = 1'b0;
      n  = 0;
      in_valid = 1'b1;
      in_data  = d;
      while (!ok && n < 100) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
         if (!ok && scramble) in_data = DATA_W'($urandom);
         n++;
      end
      if (!ok) chk("send_timeout", 32'(0), 32'(1));
      if (!keep_valid) in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (in_ready) break;
      end
      tick();
   endtask

   initial begin
      tick();
      do_reset(2);
      post_reset_check();

      // Single sample with one bit set
      send(8'h01, 1'b0, 1'b0);
      wait_idle();

      // Walking one through the line
      do_reset(1);
      post_reset_check();
      for (int i = 0; i < 8; i++) send(DATA_W'(1 << i), 1'b0, 1'b0);
      repeat (12) tick();
      @(negedge clk);
      chk("walk_x1", 32'(x1_bit), 32'h80);
      chk("walk_x8", 32'(x8_bit), 32'h01);
      tick();

      // All-ones sample into an empty line
      do_reset(1);
      send(8'hFF, 1'b0, 1'b0);
      wait_idle();

      // Reset mid-frame at bit 3
      send(8'h5A, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (slice_valid && bit_idx == 3'd2) break;
      end
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(negedge clk);
      chk("abort_bit_idx", 32'(bit_idx), 32'(3));
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("abort_in_ready", 32'(in_ready), 32'(1));
      chk("abort_valid", 32'(slice_valid), 32'(0));
      chk("abort_done", 32'(frame_done), 32'(0));
      chk("abort_x1", 32'(x1_bit), 32'(0));
      tick();
      send(8'h81, 1'b0, 1'b0);
      wait_idle();

      // Changing data offered during SERIAL
      send(8'h33, 1'b0, 1'b0);
      send(8'h44, 1'b1, 1'b0);
      wait_idle();

      // Continuous valid: one accept every DATA_W+1 cycles
      cont     = 1'b1;
      last_acc = -1;
      for (int i = 0; i < 6; i++) send(DATA_W'($urandom), 1'b0, 1'b1);
      in_valid = 1'b0;
      cont     = 1'b0;
      wait_idle();

      // Random gaps and data
      for (int i = 0; i < 30; i++) begin
         repeat ($urandom_range(0, 12)) tick();
         send(DATA_W'($urandom), 1'($urandom_range(0, 1)), 1'b0);
      end

      for (int i = 0; i < 200 && sbq.size() != 0; i++) tick();
      chk("scoreboard_drained", 32'(sbq.size()), 32'(0));
      repeat (2) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
